// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B LSB-first, one step per clock.
// Optional macro SERIAL_SUB_SATURATE_EN clamps diff to 0 on borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] diff_q;
    logic             br;
    logic             br_nxt;
    logic             borrow_q;
    logic [CW-1:0]    cnt;
    logic             a0;
    logic             b0;
    logic             d_bit;
    logic             last_step;
    logic             accept;
    logic             release_out;

    assign a0        = a_sh[0];
    assign b0        = b_sh[0];
    assign d_bit     = a0 ^ b0 ^ br;
    assign br_nxt    = (~a0 & b0) | (~(a0 ^ b0) & br);
    assign last_step = (cnt == CW'(WIDTH - 1));
    assign accept      = (state == IDLE) && in_valid;
    assign release_out = (state == DONE) && out_ready;

    // Difference bits enter at the MSB so the LSB lands in bit 0 last.
    always_comb begin
        res_nxt            = res >> 1;
        res_nxt[WIDTH-1]   = d_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (release_out) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: in_ready = 1'b1;
            RUN:  busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= res_nxt;
            br   <= br_nxt;
            cnt  <= cnt + CW'(1);
        end
    end

    // Result is captured once on entry to DONE and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if ((state == RUN) && last_step) begin
`ifdef SERIAL_SUB_SATURATE_EN
            diff_q   <= br_nxt ? '0 : res_nxt;
`else
            diff_q   <= res_nxt;
`endif
            borrow_q <= br_nxt;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
// Expected values are hand-computed; saturating build selected by macro.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;

    logic       in_valid8;
    logic       in_ready8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       out_valid8;
    logic       out_ready8;
    logic [7:0] diff8;
    logic       borrow8;
    logic       busy8;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] diff1;
    logic       borrow1;
    logic       busy1;

    int checks;
    int failures;

`ifdef SERIAL_SUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .diff      (diff8),
        .borrow    (borrow8),
        .busy      (busy8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .diff      (diff1),
        .borrow    (borrow1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one WIDTH=8 transaction; returns observations, no checking.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output logic [7:0] d,
                        output logic br, output logic ir_seen);
        a8        = av;
        b8        = bv;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        a8        = ~av;
        b8        = ~bv;
        lat       = 0;
        ir_seen   = in_ready8;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!out_valid8 && in_ready8) ir_seen = 1'b1;
        end
        d  = diff8;
        br = borrow8;
        if (out_valid8 && in_ready8) ir_seen = 1'b1;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
    endtask

    task automatic run1(input logic av, input logic bv,
                        output int lat, output logic d, output logic br);
        a1        = av;
        b1        = bv;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        lat       = 0;
        while (!out_valid1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d  = diff1;
        br = borrow1;
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b want 1", in_ready8);
        end
        checks++;
        if (out_valid8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got %b want 0", out_valid8);
        end
        checks++;
        if (diff8 !== 8'h00 || borrow8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_result got %h/%b want 00/0", diff8, borrow8);
        end
        checks++;
        if (busy8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got %b want 0", busy8);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [7:0] d;
        logic br;
        logic irs;
        run8(8'h5A, 8'h3C, lat, d, br, irs);
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL basic_latency got %0d want 8", lat);
        end
        checks++;
        if (d !== 8'h1E || br !== 1'b0) begin
            failures++;
            $display("FAIL basic_result got %h/%b want 1e/0", d, br);
        end
        checks++;
        if (irs !== 1'b0) begin
            failures++;
            $display("FAIL basic_in_ready_low got %b want 0", irs);
        end
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            failures++;
            $display("FAIL basic_release got ir=%b ov=%b want 1/0",
                     in_ready8, out_valid8);
        end
    endtask

    task automatic test_borrow();
        logic [7:0] av [4];
        logic [7:0] bv [4];
        logic [7:0] ed [4];
        logic       eb [4];
        int lat;
        logic [7:0] d;
        logic br;
        logic irs;
        av = '{8'h03, 8'h00, 8'hFF, 8'h00};
        bv = '{8'h05, 8'h01, 8'hFF, 8'hFF};
        ed = '{SAT ? 8'h00 : 8'hFE, SAT ? 8'h00 : 8'hFF,
               8'h00, SAT ? 8'h00 : 8'h01};
        eb = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run8(av[i], bv[i], lat, d, br, irs);
            checks++;
            if (d !== ed[i] || br !== eb[i] || lat !== 8) begin
                failures++;
                $display("FAIL borrow_%0d got %h/%b lat=%0d want %h/%b lat=8",
                         i, d, br, lat, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] d;
        logic br;
        a8        = 8'h77;
        b8        = 8'h22;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 8 || diff8 !== 8'h55) begin
            failures++;
            $display("FAIL bp_first got %h lat=%0d want 55 lat=8", diff8, lat);
        end
        in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a8 = 8'(i * 17 + 3);
            b8 = 8'(i * 5 + 200);
            @(posedge clk);
            #1;
            checks++;
            if (diff8 !== 8'h55 || borrow8 !== 1'b0 || out_valid8 !== 1'b1
                || in_ready8 !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d got %h/%b ov=%b ir=%b want 55/0 1/0",
                         i, diff8, borrow8, out_valid8, in_ready8);
            end
        end
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got ir=%b ov=%b busy=%b want 1/0/0",
                     in_ready8, out_valid8, busy8);
        end
        a8 = 8'h09;
        b8 = 8'h04;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_accept got busy=%b ir=%b want 1/0",
                     busy8, in_ready8);
        end
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d  = diff8;
        br = borrow8;
        checks++;
        if (lat !== 8 || d !== 8'h05 || br !== 1'b0) begin
            failures++;
            $display("FAIL bp_second got %h/%b lat=%0d want 05/0 lat=8",
                     d, br, lat);
        end
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
    endtask

    task automatic test_async_reset();
        int lat;
        logic [7:0] d;
        logic br;
        logic irs;
        a8        = 8'hAA;
        b8        = 8'h0F;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0
            || diff8 !== 8'h00 || borrow8 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got ir=%b ov=%b busy=%b %h/%b want 1/0/0 00/0",
                     in_ready8, out_valid8, busy8, diff8, borrow8);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            failures++;
            $display("FAIL async_idle got ir=%b ov=%b want 1/0",
                     in_ready8, out_valid8);
        end
        run8(8'h10, 8'h01, lat, d, br, irs);
        checks++;
        if (lat !== 8 || d !== 8'h0F || br !== 1'b0) begin
            failures++;
            $display("FAIL async_after got %h/%b lat=%0d want 0f/0 lat=8",
                     d, br, lat);
        end
    endtask

    task automatic test_width1();
        logic av [4];
        logic bv [4];
        logic ed [4];
        logic eb [4];
        int lat;
        logic d;
        logic br;
        av = '{1'b0, 1'b0, 1'b1, 1'b1};
        bv = '{1'b0, 1'b1, 1'b0, 1'b1};
        ed = '{1'b0, SAT ? 1'b0 : 1'b1, 1'b1, 1'b0};
        eb = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run1(av[i], bv[i], lat, d, br);
            checks++;
            if (d !== ed[i] || br !== eb[i] || lat !== 1) begin
                failures++;
                $display("FAIL w1_%0d got %b/%b lat=%0d want %b/%b lat=1",
                         i, d, br, lat, ed[i], eb[i]);
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        a8         = '0;
        b8         = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        a1         = '0;
        b1         = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_basic();
        test_borrow();
        test_back_to_back();
        test_async_reset();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor: the subtracting counterpart of the adder datapath.
- Accepts an A/B operand pair over a valid/ready handshake.
- Computes A - B LSB-first, one full-subtractor step per clock, with a registered borrow.
- Returns the difference and final borrow over a second valid/ready handshake.
- Intended as the area-cheap arithmetic element for multi-cycle datapaths.

Parameters:
- WIDTH, 8, operand and difference width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  diff/borrow hold a completed result.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  A - B modulo 2^WIDTH (see Optional Feature).
- borrow  output  1  1 when A < B, unsigned.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, busy=0; internal shift registers, borrow register and bit counter all 0.
- Reset is honoured in any state, including mid-RUN: the partial result is discarded, nothing is emitted, and the block is in IDLE on the first edge after rst falls.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a and b into shift registers, clear the borrow register and counter, go to RUN.
  - a/b are sampled only on this edge; later changes to a/b have no effect.
- RUN:
  - in_ready=0.
  - Each edge, with a0/b0 the current LSBs and br the borrow register:
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift d into the MSB of the result register, shift both operands right by one, increment the counter.
  - After WIDTH steps, go to DONE.
- DONE:
  - out_valid=1.
  - diff and borrow are held stable until the handshake.
  - On an edge with out_ready=1: go to IDLE; out_valid=0 from that edge.
- Latency: out_valid rises exactly WIDTH clocks after the accepting edge. For WIDTH=8, accept at edge N gives out_valid high after edge N+8.
- Throughput: one operation per WIDTH+2 clocks minimum. No overlap: in_valid is ignored while busy, and there is no input skid buffer.
- in_ready rises on the edge that completes the output handshake. A new pair presented on the next edge is accepted.
- Arithmetic:
  - Operands are unsigned.
  - borrow equals the borrow-out of the MSB step.
  - diff is A - B mod 2^WIDTH.
- Boundary cases:
  - WIDTH=1 gives RUN for exactly one cycle.
  - A == B gives diff=0, borrow=0.
  - A=0, B=2^WIDTH-1 gives diff=1, borrow=1.
- out_ready asserted outside DONE has no effect.
- diff/borrow keep the last result after returning to IDLE until the next DONE. They are meaningful only while out_valid=1.
- Counter width: clog2(WIDTH+1) bits; it must not wrap for WIDTH=32.

Optional Feature:
- Macro: SERIAL_SUB_SATURATE_EN.
- Defined: when the final borrow=1, diff is forced to 0 on entry to DONE (saturating unsigned subtraction). borrow is still reported as 1.
- Undefined: diff is the wrapped modulo-2^WIDTH result. There is no saturation logic.

Test Plan (WIDTH=8 unless noted):
- a=0x5A, b=0x3C accepted at edge N -> out_valid high after edge N+8, diff=0x1E, borrow=0; in_ready=0 from N+1 until the output handshake.
- a=0x03, b=0x05 -> diff=0xFE, borrow=1; with SERIAL_SUB_SATURATE_EN, diff=0x00, borrow=1.
- a=0x00, b=0x01 (full borrow ripple) -> diff=0xFF, borrow=1; a=0xFF, b=0xFF -> diff=0x00, borrow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b -> diff/borrow stable, no second accept; raise out_ready -> in_ready=1 after that edge, next pair accepted on the following edge.
- Assert rst asynchronously (not clock-aligned) 3 cycles into RUN -> all outputs drop to reset values immediately; after release, a=0x10, b=0x01 gives diff=0x0F, borrow=0, with no stale output.
- WIDTH=1 build: all four (a,b) combinations -> diff/borrow match the half-subtractor truth table, out_valid 1 clock after accept.
